shift_add_multiplier_16b: RTL and testbench



---
 rtl/shift_add_multiplier_16b.sv | 181 ++++++++++++++++++
 tb/tb_shift_add_multiplier_16b.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_16b.sv
// rtl/shift_add_multiplier_16b.sv - radix-2 shift-add 16x16->32 unsigned multiplier
// Sixteen iterations through one carry-lookahead adder, with a start/busy/done handshake.

module carry_lookahead_adder_16b (
  input  logic [15:0] iA,
  input  logic [15:0] iB,
  input  logic        iCarryIn,
  output logic [15:0] oSum,
  output logic        oCarryOut
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [3:0]  grpGen;
  logic [3:0]  grpProp;
  logic [4:0]  grpCarry;
  logic [15:0] carry;

  // Bit and 4-bit group generate/propagate terms.
  always_comb begin
    gen     = iA & iB;
    prop    = iA ^ iB;
    grpGen  = '0;
    grpProp = '0;
    for (int k = 0; k < 4; k++) begin
      grpGen[k]  = gen[4*k+3]
                 | (prop[4*k+3] & gen[4*k+2])
                 | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                 | ((&prop[4*k+3 -: 3]) & gen[4*k]);
      grpProp[k] = &prop[4*k +: 4];
    end
  end

  // Second-level lookahead across the four groups.
  always_comb begin
    grpCarry[0] = iCarryIn;
    grpCarry[1] = grpGen[0] | (grpProp[0] & iCarryIn);
    grpCarry[2] = grpGen[1] | (grpProp[1] & grpGen[0])
                | (grpProp[1] & grpProp[0] & iCarryIn);
    grpCarry[3] = grpGen[2] | (grpProp[2] & grpGen[1])
                | (grpProp[2] & grpProp[1] & grpGen[0])
                | (grpProp[2] & grpProp[1] & grpProp[0] & iCarryIn);
    grpCarry[4] = grpGen[3] | (grpProp[3] & grpGen[2])
                | (grpProp[3] & grpProp[2] & grpGen[1])
                | (grpProp[3] & grpProp[2] & grpProp[1] & grpGen[0])
                | (grpProp[3] & grpProp[2] & grpProp[1] & grpProp[0] & iCarryIn);
  end

  always_comb begin
    carry = '0;
    for (int k = 0; k < 4; k++) begin
      carry[4*k]   = grpCarry[k];
      carry[4*k+1] = gen[4*k] | (prop[4*k] & grpCarry[k]);
      carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & grpCarry[k]);
      carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grpCarry[k]);
    end
  end

  assign oSum      = prop ^ carry;
  assign oCarryOut = grpCarry[4];

endmodule

module shift_add_multiplier_16b #(
  parameter int WIDTH = 16
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProduct
);

  generate
    if (WIDTH != 16) begin : gWidthCheck
      $error("shift_add_multiplier_16b: WIDTH must be 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT              state;
  stateT              stateNext;
  logic [WIDTH-1:0]   rMcand;
  logic [2*WIDTH-1:0] rAcc;
  logic [4:0]         rCnt;
  logic [WIDTH-1:0]   adderAddend;
  logic [WIDTH-1:0]   adderSum;
  logic               adderCarry;
  logic [2*WIDTH-1:0] accNext;
  logic               lastIter;

  // Add the multiplicand only when the current multiplier bit is set.
  assign adderAddend = rAcc[0] ? rMcand : '0;

  carry_lookahead_adder_16b uAdder (
    .iA        (rAcc[2*WIDTH-1:WIDTH]),
    .iB        (adderAddend),
    .iCarryIn  (1'b0),
    .oSum      (adderSum),
    .oCarryOut (adderCarry)
  );

  // Carry becomes bit 31 so the 33-bit partial sum never loses its top bit.
  assign accNext  = {adderCarry, adderSum, rAcc[WIDTH-1:1]};
  assign lastIter = (rCnt == 5'd15);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        oBusy = 1'b1;
        if (lastIter) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        oBusy     = 1'b1;
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rMcand   <= '0;
      rAcc     <= '0;
      rCnt     <= '0;
      oProduct <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            rMcand <= iA;
            rAcc   <= {{WIDTH{1'b0}}, iB};
            rCnt   <= '0;
          end
        end
        RUN: begin
          rAcc <= accNext;
          rCnt <= rCnt + 5'd1;
          if (lastIter) begin
            oProduct <= accNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_16b.sv
// tb/tb_shift_add_multiplier_16b.sv - directed and random checks of shift_add_multiplier_16b against a*b

module tb_shift_add_multiplier_16b;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oProduct;

  int          nVec  = 0;
  int          nFail = 0;
  logic [31:0] prevExp = 32'h0;

  shift_add_multiplier_16b #(.WIDTH(16)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStart   (iStart),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oProduct (oProduct)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of run, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refMul(input logic [15:0] a, input logic [15:0] b);
    return {16'h0, a} * {16'h0, b};
  endfunction

  // One full operation from an idle DUT; noise scrambles inputs during the run.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input bit noise);
    int k;
    logic [31:0] exp;
    exp = refMul(a, b);
    @(negedge iClk);
    iA = a; iB = b; iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    k = 0;
    while (!oDone && k < 40) begin
      if (k == 8) begin
        check("busyMidRun", {31'h0, oBusy}, 32'h1);
        check("productHold", oProduct, prevExp);
      end
      if (noise) begin
        iStart = 1'($urandom);
        iA = 16'($urandom);
        iB = 16'($urandom);
      end
      @(posedge iClk);
      @(negedge iClk);
      k++;
    end
    check("latency", 32'(k), 32'd16);
    check("product", oProduct, exp);
    check("busyInDone", {31'h0, oBusy}, 32'h1);
    if (noise) iStart = 1'($urandom);
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    check("doneOneCycle", {31'h0, oDone}, 32'h0);
    check("busyAfter", {31'h0, oBusy}, 32'h0);
    check("productKept", oProduct, exp);
    prevExp = exp;
  endtask

  initial begin
    int  k;
    bit  sawDone;
    logic [15:0] a;
    logic [15:0] b;

    iRst = 1'b1; iStart = 1'b0; iA = 16'h0; iB = 16'h0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    check("rstBusy", {31'h0, oBusy}, 32'h0);
    check("rstDone", {31'h0, oDone}, 32'h0);
    check("rstProduct", oProduct, 32'h0);

    runOp(16'd3, 16'd5, 1'b0);
    runOp(16'hFFFF, 16'hFFFF, 1'b0);
    check("maxProduct", oProduct, 32'hFFFE0001);
    runOp(16'h1234, 16'h0000, 1'b0);
    runOp(16'h0000, 16'hBEEF, 1'b0);

    // Start held high: first result 17 edges after the first, then one every 18.
    @(negedge iClk);
    iA = 16'h8000; iB = 16'h0002; iStart = 1'b1;
    k = 0;
    do begin
      @(posedge iClk); @(negedge iClk); k++;
    end while (!oDone && k < 40);
    check("heldFirstLatency", 32'(k), 32'd17);
    check("heldFirstProduct", oProduct, 32'h00010000);
    k = 0;
    do begin
      @(posedge iClk); @(negedge iClk); k++;
    end while (!oDone && k < 40);
    check("heldPeriod", 32'(k), 32'd18);
    check("heldSecondProduct", oProduct, 32'h00010000);
    iStart = 1'b0;
    @(posedge iClk); @(negedge iClk);
    check("heldIdle", {31'h0, oBusy}, 32'h0);
    prevExp = 32'h00010000;

    // Reset arriving at the ninth edge of a run aborts it.
    @(negedge iClk);
    iA = 16'd7; iB = 16'd9; iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    repeat (7) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    check("abortBusy", {31'h0, oBusy}, 32'h0);
    check("abortDone", {31'h0, oDone}, 32'h0);
    check("abortProduct", oProduct, 32'h0);
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge iClk); @(negedge iClk);
      if (oDone) sawDone = 1'b1;
    end
    check("abortNoDone", {31'h0, sawDone}, 32'h0);
    prevExp = 32'h0;
    runOp(16'd7, 16'd9, 1'b0);
    check("afterAbort", oProduct, 32'h0000003F);

    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 97 == 0) a = 16'hFFFF;
      if (i % 89 == 0) b = 16'h0000;
      runOp(a, b, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
